// File: rtl/ch376s_spi_responder.sv
// CH376S-style SPI slave responder with a byte-wide host register interface (data / status).
// Optional interrupt output int_n is built only when CH376S_RESP_INT_EN is defined.
module ch376s_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdcs,
    input  logic       sdi,
    output logic       sdo,
    input  logic       rd,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout
`ifdef CH376S_RESP_INT_EN
    ,
    output logic       int_n
`endif
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdcs_sync_q, sdcs_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   rd_dly_q, rd_dly_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic [7:0]             tx_hold_q, tx_hold_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   rx_full_q, rx_full_d;
    logic                   overrun_q, overrun_d;
    logic                   sdo_q, sdo_d;

    logic       sck_s, sdcs_s, sdi_s;
    logic       sck_rise, sck_fall;
    logic       rd_clr, load, byte_done;
    logic [7:0] load_byte;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdcs_s   = sdcs_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    // Clear rx_full once per read access, not for every cycle rd stays high
    assign rd_clr   = rd & ~rd_dly_q & ~a0;
    assign load_byte = tx_valid_q ? tx_hold_q : IDLE_BYTE;

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        sdcs_sync_d = {sdcs_sync_q[SYNC_STAGES-2:0], sdcs};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        sck_dly_d   = sck_s;
        rd_dly_d    = rd;
        bitcnt_d    = bitcnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        tx_hold_d   = tx_hold_q;
        tx_valid_d  = tx_valid_q;
        rx_full_d   = rx_full_q;
        overrun_d   = overrun_q;
        sdo_d       = sdo_q;
        load        = 1'b0;
        byte_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                sdo_d = 1'b1;
                if (!sdcs_s) begin
                    state_d  = StShift;
                    bitcnt_d = 3'd0;
                    load     = 1'b1;
                end
            end
            StShift: begin
                if (sdcs_s) begin
                    state_d  = StIdle;
                    bitcnt_d = 3'd0;
                    sdo_d    = 1'b1;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], sdi_s};
                    bitcnt_d   = bitcnt_q + 3'd1;
                    byte_done  = (bitcnt_q == 3'd7);
                end else if (sck_fall) begin
                    // bitcnt already wrapped on the 8th rise, so this is the byte's last fall
                    if (bitcnt_q == 3'd0) begin
                        load = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b1};
                        sdo_d      = tx_shift_q[6];
                    end
                end
            end
        endcase

        if (load) begin
            tx_shift_d = load_byte;
            sdo_d      = load_byte[7];
            tx_valid_d = 1'b0;
        end

        // Host write takes effect after any same-cycle load, which saw the old values
        if (wr && !a0) begin
            tx_hold_d  = din;
            tx_valid_d = 1'b1;
        end
        if (wr && a0 && din[2]) begin
            overrun_d = 1'b0;
        end

        if (byte_done) begin
            rx_data_d = {rx_shift_q[6:0], sdi_s};
            rx_full_d = 1'b1;
            if (rx_full_q && !rd_clr) begin
                overrun_d = 1'b1;
            end
        end else if (rd_clr) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            sck_sync_q  <= '0;
            sdcs_sync_q <= '1;
            sdi_sync_q  <= '0;
            sck_dly_q   <= 1'b0;
            rd_dly_q    <= 1'b0;
            bitcnt_q    <= 3'd0;
            tx_shift_q  <= IDLE_BYTE;
            rx_shift_q  <= IDLE_BYTE;
            rx_data_q   <= 8'h00;
            tx_hold_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            sdo_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            sdcs_sync_q <= sdcs_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sck_dly_q   <= sck_dly_d;
            rd_dly_q    <= rd_dly_d;
            bitcnt_q    <= bitcnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            tx_hold_q   <= tx_hold_d;
            tx_valid_q  <= tx_valid_d;
            rx_full_q   <= rx_full_d;
            overrun_q   <= overrun_d;
            sdo_q       <= sdo_d;
        end
    end

    assign sdo = sdo_q;

    always_comb begin
        dout = 8'h00;
        if (rd) begin
            dout = a0 ? {4'b0000, (state_q == StShift), overrun_q, ~tx_valid_q, rx_full_q}
                      : rx_data_q;
        end
    end

`ifdef CH376S_RESP_INT_EN
    logic int_n_q, int_n_d;

    assign int_n_d = ~(rx_full_q | overrun_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_n_q <= 1'b1;
        end else begin
            int_n_q <= int_n_d;
        end
    end

    assign int_n = int_n_q;
`endif

endmodule
